// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter in front of the single-port
// 64x8 rammod. Issues one command per cycle on the ram_* pins and returns
// tagged read data to whichever requester issued the read.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  requester A command (held until a_gnt)
//   a_gnt                      A command issued this cycle (pulse)
//   a_rvalid/a_rdata           A read return (pulse / held data)
//   b_*                        same set for requester B
//   a_lock, b_lock             ownership hold (only with RAM_ARB_LOCK_EN)
//   ram_we/ram_addr/ram_din    registered command to rammod
//   ram_dout                   rammod read data (RD_LAT cycles after command)
//
// Optional feature: define RAM_ARB_LOCK_EN to add the lock inputs.
module ram_arbiter #(
  parameter int unsigned AW     = 6,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic          a_lock,
  input  logic          b_lock,
`endif
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  // Pointer names the requester favoured on a tie (the one not granted last).
  typedef enum logic {FAV_A, FAV_B} rr_e;

  rr_e           rr_q, rr_d;
  logic          a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  // Read-tag shift register: valid bit and requester id (1 = B) per stage.
  logic [RD_LAT:0] tv_q, tv_d, tid_q, tid_d;

  logic a_elig, b_elig, grant_a, grant_b;

`ifdef RAM_ARB_LOCK_EN
  // Set once any grant has happened, so the pointer also identifies the
  // holder of the most recent grant.
  logic owned_q, owned_d;
`endif

  always_comb begin
    // A requester granted last cycle sits out one edge so a held req is
    // never issued twice.
    a_elig = a_req & ~a_gnt_q;
    b_elig = b_req & ~b_gnt_q;
`ifdef RAM_ARB_LOCK_EN
    if (owned_q && (rr_q == FAV_B) && a_lock && a_req) b_elig = 1'b0;
    if (owned_q && (rr_q == FAV_A) && b_lock && b_req) a_elig = 1'b0;
`endif
    grant_a = a_elig & (~b_elig | (rr_q == FAV_A));
    grant_b = b_elig & ~grant_a;
  end

  always_comb begin
    a_gnt_d    = grant_a;
    b_gnt_d    = grant_b;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rr_d       = rr_q;
    if (grant_a) begin
      ram_we_d   = a_we;
      ram_addr_d = a_addr;
      ram_din_d  = a_wdata;
      rr_d       = FAV_B;
    end else if (grant_b) begin
      ram_we_d   = b_we;
      ram_addr_d = b_addr;
      ram_din_d  = b_wdata;
      rr_d       = FAV_A;
    end

    tv_d     = '0;
    tid_d    = '0;
    tv_d[0]  = (grant_a & ~a_we) | (grant_b & ~b_we);
    tid_d[0] = grant_b;
    for (int unsigned i = 1; i <= RD_LAT; i++) begin
      tv_d[i]  = tv_q[i-1];
      tid_d[i] = tid_q[i-1];
    end

    // The last tag stage lines up with ram_dout for that read.
    a_rvalid_d = tv_q[RD_LAT] & ~tid_q[RD_LAT];
    b_rvalid_d = tv_q[RD_LAT] & tid_q[RD_LAT];
    a_rdata_d  = a_rvalid_d ? ram_dout : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? ram_dout : b_rdata_q;
  end

`ifdef RAM_ARB_LOCK_EN
  always_comb owned_d = owned_q | grant_a | grant_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owned_q <= 1'b0;
    else        owned_q <= owned_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= FAV_A;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      tv_q       <= '0;
      tid_q      <= '0;
    end else begin
      rr_q       <= rr_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      tv_q       <= tv_d;
      tid_q      <= tid_d;
    end
  end

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural rammod beside it.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [5:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
`ifdef RAM_ARB_LOCK_EN
  logic       a_lock, b_lock;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(6), .DW(8), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef RAM_ARB_LOCK_EN
    .a_lock(a_lock), .b_lock(b_lock),
`endif
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // rammod: synchronous write, registered read on the same edge.
  logic [7:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    ram_dout = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Mutual exclusion of grants and of read returns, every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((a_gnt && b_gnt) || (a_rvalid && b_rvalid)) begin
        errors++;
        $display("FAIL excl: gnt=%b%b rvalid=%b%b required no overlap",
                 a_gnt, b_gnt, a_rvalid, b_rvalid);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".gnt"}, 32'({a_gnt, b_gnt}), 32'd0);
    chk({nm, ".rvalid"}, 32'({a_rvalid, b_rvalid}), 32'd0);
    chk({nm, ".ram_we"}, 32'(ram_we), 32'd0);
    chk({nm, ".ram_addr"}, 32'(ram_addr), 32'd0);
    chk({nm, ".ram_din"}, 32'(ram_din), 32'd0);
    chk({nm, ".rdata"}, 32'({a_rdata, b_rdata}), 32'd0);
  endtask

  typedef struct {
    logic       a_req, a_we;
    logic [5:0] a_addr;
    logic [7:0] a_wd;
    logic       b_req, b_we;
    logic [5:0] b_addr;
    logic [7:0] b_wd;
    logic       e_ag, e_bg, e_we;
    logic [5:0] e_addr;
    logic [7:0] e_din;
    logic       e_arv;
    logic [7:0] e_ard;
    logic       e_brv;
    logic [7:0] e_brd;
  } vec_t;

  vec_t tbl [20];

  initial begin
    // A writes 1..3 alone, reads them back, then A/B contend with a
    // same-address write-then-read.
    tbl[0]  = '{1'b1,1'b1,6'h01,8'h01, 1'b0,1'b0,6'h00,8'h00, 1'b1,1'b0,1'b1,6'h01,8'h01, 1'b0,8'h00,1'b0,8'h00};
    tbl[1]  = '{1'b1,1'b1,6'h02,8'h02, 1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,1'b0,6'h01,8'h01, 1'b0,8'h00,1'b0,8'h00};
    tbl[2]  = '{1'b1,1'b1,6'h02,8'h02, 1'b0,1'b0,6'h00,8'h00, 1'b1,1'b0,1'b1,6'h02,8'h02, 1'b0,8'h00,1'b0,8'h00};
    tbl[3]  = '{1'b1,1'b1,6'h03,8'h03, 1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,1'b0,6'h02,8'h02, 1'b0,8'h00,1'b0,8'h00};
    tbl[4]  = '{1'b1,1'b1,6'h03,8'h03, 1'b0,1'b0,6'h00,8'h00, 1'b1,1'b0,1'b1,6'h03,8'h03, 1'b0,8'h00,1'b0,8'h00};
    tbl[5]  = '{1'b1,1'b0,6'h01,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,1'b0,6'h03,8'h03, 1'b0,8'h00,1'b0,8'h00};
    tbl[6]  = '{1'b1,1'b0,6'h01,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b1,1'b0,1'b0,6'h01,8'h00, 1'b0,8'h00,1'b0,8'h00};
    tbl[7]  = '{1'b1,1'b0,6'h02,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,1'b0,6'h01,8'h00, 1'b0,8'h00,1'b0,8'h00};
    tbl[8]  = '{1'b1,1'b0,6'h02,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b1,1'b0,1'b0,6'h02,8'h00, 1'b1,8'h01,1'b0,8'h00};
    tbl[9]  = '{1'b1,1'b0,6'h03,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,1'b0,6'h02,8'h00, 1'b0,8'h01,1'b0,8'h00};
    tbl[10] = '{1'b1,1'b0,6'h03,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b1,1'b0,1'b0,6'h03,8'h00, 1'b1,8'h02,1'b0,8'h00};
    tbl[11] = '{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,1'b0,6'h03,8'h00, 1'b0,8'h02,1'b0,8'h00};
    tbl[12] = '{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,1'b0,6'h03,8'h00, 1'b1,8'h03,1'b0,8'h00};
    tbl[13] = '{1'b1,1'b1,6'h10,8'h11, 1'b1,1'b1,6'h20,8'h22, 1'b0,1'b1,1'b1,6'h20,8'h22, 1'b0,8'h03,1'b0,8'h00};
    tbl[14] = '{1'b1,1'b1,6'h10,8'h11, 1'b1,1'b0,6'h10,8'h00, 1'b1,1'b0,1'b1,6'h10,8'h11, 1'b0,8'h03,1'b0,8'h00};
    tbl[15] = '{1'b1,1'b0,6'h20,8'h00, 1'b1,1'b0,6'h10,8'h00, 1'b0,1'b1,1'b0,6'h10,8'h00, 1'b0,8'h03,1'b0,8'h00};
    tbl[16] = '{1'b1,1'b0,6'h20,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b1,1'b0,1'b0,6'h20,8'h00, 1'b0,8'h03,1'b0,8'h00};
    tbl[17] = '{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,1'b0,6'h20,8'h00, 1'b0,8'h03,1'b1,8'h11};
    tbl[18] = '{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,1'b0,6'h20,8'h00, 1'b1,8'h22,1'b0,8'h11};
    tbl[19] = '{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,1'b0,6'h20,8'h00, 1'b0,8'h22,1'b0,8'h11};

    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
    a_lock = 1'b0; b_lock = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      chk_zero("idle");
    end

    for (int i = 0; i < 20; i++) begin
      a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wd;
      b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wd;
      step();
      chk($sformatf("v%0d.a_gnt", i), 32'(a_gnt), 32'(tbl[i].e_ag));
      chk($sformatf("v%0d.b_gnt", i), 32'(b_gnt), 32'(tbl[i].e_bg));
      chk($sformatf("v%0d.ram_we", i), 32'(ram_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d.ram_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d.ram_din", i), 32'(ram_din), 32'(tbl[i].e_din));
      chk($sformatf("v%0d.a_rvalid", i), 32'(a_rvalid), 32'(tbl[i].e_arv));
      chk($sformatf("v%0d.a_rdata", i), 32'(a_rdata), 32'(tbl[i].e_ard));
      chk($sformatf("v%0d.b_rvalid", i), 32'(b_rvalid), 32'(tbl[i].e_brv));
      chk($sformatf("v%0d.b_rdata", i), 32'(b_rdata), 32'(tbl[i].e_brd));
    end

    // Continuous contention; last grant was A so B goes first.
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'h30; a_wdata = 8'h33;
    b_req = 1'b1; b_we = 1'b1; b_addr = 6'h31; b_wdata = 8'h44;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rr%0d.a_gnt", k), 32'(a_gnt), 32'(k % 2));
      chk($sformatf("rr%0d.b_gnt", k), 32'(b_gnt), 32'(1 - (k % 2)));
      chk($sformatf("rr%0d.ram_we", k), 32'(ram_we), 32'd1);
      chk($sformatf("rr%0d.ram_addr", k), 32'(ram_addr), (k % 2 == 1) ? 32'h30 : 32'h31);
    end
    a_req = 1'b0; b_req = 1'b0;
    step();

    // A writes 0x3F, B reads it on the following grant.
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'h3F; a_wdata = 8'hAA;
    step();
    chk("wr3f.a_gnt", 32'(a_gnt), 32'd1);
    chk("wr3f.ram_we", 32'(ram_we), 32'd1);
    chk("wr3f.ram_addr", 32'(ram_addr), 32'h3F);
    chk("wr3f.ram_din", 32'(ram_din), 32'hAA);
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'h3F; b_wdata = 8'h00;
    step();
    chk("rd3f.b_gnt", 32'(b_gnt), 32'd1);
    chk("rd3f.ram_we", 32'(ram_we), 32'd0);
    b_req = 1'b0;
    step();
    chk("rd3f.early_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    step();
    chk("rd3f.b_rvalid", 32'(b_rvalid), 32'd1);
    chk("rd3f.b_rdata", 32'(b_rdata), 32'hAA);
    chk("rd3f.a_rvalid", 32'(a_rvalid), 32'd0);
    step();
    chk("rd3f.a_rdata_hold", 32'(a_rdata), 32'h22);
    chk("rd3f.b_rvalid_pulse", 32'(b_rvalid), 32'd0);

    // Reads in flight from B then A, reset during the second grant cycle.
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'h03;
    step();
    chk("rst.b_gnt", 32'(b_gnt), 32'd1);
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'h05; a_wdata = 8'h00;
    step();
    chk("rst.a_gnt", 32'(a_gnt), 32'd1);
    a_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("rst.async");
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rst.post%0d.rvalid", k), 32'({a_rvalid, b_rvalid}), 32'd0);
      chk($sformatf("rst.post%0d.gnt", k), 32'({a_gnt, b_gnt}), 32'd0);
    end
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'h08; a_wdata = 8'h5A;
    b_req = 1'b1; b_we = 1'b1; b_addr = 6'h09; b_wdata = 8'hA5;
    step();
    chk("rst.first_a_gnt", 32'(a_gnt), 32'd1);
    chk("rst.first_b_gnt", 32'(b_gnt), 32'd0);
    a_req = 1'b0; b_req = 1'b0;
    step();

`ifdef RAM_ARB_LOCK_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'h0A; a_wdata = 8'h01; a_lock = 1'b1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 6'h0B; b_wdata = 8'h02;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("lock%0d.a_gnt", k), 32'(a_gnt), 32'(1 - (k % 2)));
      chk($sformatf("lock%0d.b_gnt", k), 32'(b_gnt), 32'd0);
    end
    a_lock = 1'b0;
    step();
    chk("unlock.b_gnt", 32'(b_gnt), 32'd1);
    chk("unlock.a_gnt", 32'(a_gnt), 32'd0);
    a_req = 1'b0; b_req = 1'b0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
